booth_seq_mul: RTL and testbench
================================

// Module: booth_seq_mul
// PURPOSE
//   Sequential radix-2 Booth multiplier: controller FSM plus working registers that
//   sequence one add/sub + arithmetic-shift step per clock over WIDTH cycles.
//   Replaces the combinational Booth netlist where area matters more than latency.
//   Sits between an operand source (start/ready handshake) and a product sink (done pulse).
// PARAMETERS
//   WIDTH  4  operand width in bits; md and mr are signed two's complement; WIDTH >= 2
// PORTS
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        request; accepted only in a cycle where ready=1
//   md       in   WIDTH    multiplicand, signed; sampled on the accepting edge
//   mr       in   WIDTH    multiplier, signed; sampled on the accepting edge
//   ready    out  1        1 = IDLE or DONE, a new start will be accepted
//   busy     out  1        1 while iterating (RUN)
//   done     out  1        one-cycle pulse; product valid from this cycle
//   product  out  2*WIDTH  signed md*mr; held until the next done
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, ready=1, busy=0, done=0,
//   product=0, all working regs=0.
// - Working regs:
//   - A: WIDTH+1 bits; the extra bit absorbs -M for md=-2^(WIDTH-1).
//   - Q, M: WIDTH bits each.
//   - q_1: 1 bit.
//   - cnt: clog2(WIDTH+1) bits.
// - FSM states IDLE, RUN, DONE.
//   - IDLE: start=1 -> RUN; load A=0, Q=mr, q_1=0, M=md, cnt=0.
//   - IDLE: start=0 -> stay.
//   - RUN, each cycle:
//     - Choose A' from {Q[0],q_1}: 01 -> A+sext(M); 10 -> A-sext(M); 00/11 -> A.
//     - Then {A,Q,q_1} <= arithmetic shift right of {A',Q,q_1} by 1, sign = A'[WIDTH].
//     - cnt <= cnt+1.
//   - RUN exit: on the edge where cnt==WIDTH-1 -> DONE; product <= {A[WIDTH-1:0],Q}
//     after that final step.
//   - DONE: done=1, ready=1 for exactly one cycle.
//     - start=1 -> RUN, new operands loaded (back-to-back).
//     - start=0 -> IDLE.
// - Latency: start accepted in cycle 0 -> busy=1 cycles 1..WIDTH -> done=1 in cycle
//   WIDTH+1. Issue interval is WIDTH+1 cycles.
// - Arithmetic: add/sub modulo 2^(WIDTH+1). The full signed product always fits 2*WIDTH
//   bits; no overflow flag. product is updated only on the DONE entry edge.
// - start while busy=1 is ignored; no queueing; md/mr may change freely during RUN.
// - done never asserts without a preceding accepted start; product is unchanged
//   when done=0.
// - rst_n low mid-RUN: immediate abort; outputs return to reset values; no done for
//   the aborted operation; first start after release behaves as a fresh op.
// - Outputs are registered or decoded from state only; no combinational path from
//   md/mr/start to any output.
// TESTING (WIDTH=4)
//   1. Reset, then start=1 with md=3, mr=5 in cycle 0 -> busy cycles 1-4; done=1,
//      product=8'h0F in cycle 5; done=0 in cycle 6.
//   2. Corner operands:
//      - md=-8, mr=-8 -> product=8'h40.
//      - md=-8, mr=7 -> product=8'hC8.
//      - md=-3, mr=5 -> product=8'hF1.
//      - md=0, mr=-1 -> product=8'h00.
//   3. Exhaustive sweep of all 256 md/mr pairs vs reference model: product==md*mr
//      each done; issue interval 5 cycles.
//   4. Hold start=1 continuously: accepted in cycles 0, 5, 10, ...; pulses in cycles
//      1-4 ignored; exactly one done per accepted start.
//   5. md=3, mr=5 started, then md/mr changed in cycle 2 -> product still 8'h0F.
//      Separately: rst_n=0 in cycle 3 -> busy=0, ready=1, product=0, no done.
//      Then md=2, mr=-2 -> product=8'hFC.
//   6. Back-to-back: md=1, mr=1 then md=7, mr=7 started in the done cycle -> 8'h01 in
//      cycle 5, 8'h31 in cycle 10; product holds 8'h01 in cycles 6-9.

Source files
------------

// File: rtl/booth_seq_mul_if.sv
// Operand/product bus of the sequential Booth multiplier.
//
// Handshake: the source raises start with md/mr valid; the request is taken
// on the rising edge where start=1 and ready=1, and md/mr are sampled on that
// same edge. A start seen while ready=0 is dropped, not queued. done is a
// single-cycle pulse; product is valid from that cycle and is held until the
// next done.
interface booth_seq_mul_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     md;
    logic [WIDTH-1:0]     mr;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [1:0]           state_dbg;   // controller state, for observation only

    // Operand source / product sink side
    modport master (
        output start, md, mr,
        input  ready, busy, done, product, state_dbg
    );

    // Multiplier side
    modport slave (
        input  start, md, mr,
        output ready, busy, done, product, state_dbg
    );
endinterface

// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier.
// One add/subtract plus arithmetic right shift per clock, WIDTH steps per
// operation. The accumulator A carries one extra bit so that subtracting the
// most negative multiplicand (-2^(WIDTH-1)) cannot overflow.
// All outputs come from registers or from the state register alone.
module booth_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_seq_mul_if.slave     bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;

    // Working registers
    logic [WIDTH:0]       a_q;
    logic [WIDTH-1:0]     q_q;
    logic [WIDTH-1:0]     m_q;
    logic                 q1_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   product_q;

    // Controller decisions
    logic                 load;
    logic                 step;
    logic                 last;

    // Datapath intermediates
    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       a_alu;
    logic [WIDTH:0]       a_shift;
    logic [WIDTH-1:0]     q_shift;
    logic                 q1_shift;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle datapath control
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                // cnt counts completed steps; the step taken while cnt==WIDTH-1 is the final one
                if (cnt_q == CW'(WIDTH - 1)) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // A start in the done cycle is taken immediately (back-to-back issue)
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Booth step: pick A +/- M from the recoded pair {Q[0], q_1}, then shift {A,Q,q_1} right
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        case ({q_q[0], q1_q})
            2'b01:   a_alu = a_q + m_ext;
            2'b10:   a_alu = a_q - m_ext;
            default: a_alu = a_q;
        endcase
        a_shift  = {a_alu[WIDTH], a_alu[WIDTH:1]};
        q_shift  = {a_alu[0], q_q[WIDTH-1:1]};
        q1_shift = q_q[0];
    end

    // Working registers: load fresh operands on acceptance, otherwise step while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            q_q   <= '0;
            m_q   <= '0;
            q1_q  <= 1'b0;
            cnt_q <= '0;
        end else if (load) begin
            a_q   <= '0;
            q_q   <= bus.mr;
            m_q   <= bus.md;
            q1_q  <= 1'b0;
            cnt_q <= '0;
        end else if (step) begin
            a_q   <= a_shift;
            q_q   <= q_shift;
            q1_q  <= q1_shift;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Product register: captures the result of the final step, then holds it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q <= '0;
        end else if (last) begin
            product_q <= {a_shift[WIDTH-1:0], q_shift};
        end
    end

    assign bus.ready     = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.product   = product_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed bench for booth_seq_mul (WIDTH=4) with a product scoreboard.
module tb_booth_seq_mul;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Clock and reset
    always #5 clk = ~clk;

    booth_seq_mul_if #(.WIDTH(W)) bus ();

    booth_seq_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [2*W-1:0] exp_q[$];
    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int accepts     = 0;
    int dones       = 0;
    int last_accept = 0;

    // Reference: signed product truncated to 2*W bits
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int pa;
        int pb;
        int p;
        pa = int'($signed(a));
        pb = int'($signed(b));
        p  = pa * pb;
        return p[2*W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle; push on acceptance, pop and compare on done
    task automatic tick();
        logic [2*W-1:0] e;
        if (rst_n && bus.start && bus.ready) begin
            exp_q.push_back(model(bus.md, bus.mr));
            accepts++;
            last_accept = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (bus.done) begin
            dones++;
            check("done_has_op", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_product", 32'(bus.product), 32'(e));
            end
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.md    = a;
        bus.mr    = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!bus.done && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", 32'(bus.done), 32'd1);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   c_md [4];
        logic [W-1:0]   c_mr [4];
        logic [2*W-1:0] c_p  [4];
        logic [7:0]     v;
        int prev_acc;
        int base_cyc;
        int base_acc;
        int base_done;
        int c5;
        int n_acc;

        c_md = '{4'h8, 4'h8, 4'hD, 4'h0};
        c_mr = '{4'h8, 4'h7, 4'h5, 4'hF};
        c_p  = '{8'h40, 8'hC8, 8'hF1, 8'h00};

        bus.start = 1'b0;
        bus.md    = '0;
        bus.mr    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",   32'(bus.ready),     32'd1);
        check("rst_busy",    32'(bus.busy),      32'd0);
        check("rst_done",    32'(bus.done),      32'd0);
        check("rst_product", 32'(bus.product),   32'd0);
        check("rst_state",   32'(bus.state_dbg), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1. 3*5 with cycle-exact latency
        start_op(4'd3, 4'd5);
        for (int c = 1; c <= 4; c++) begin
            check("t1_busy",  32'(bus.busy),  32'd1);
            check("t1_ready", 32'(bus.ready), 32'd0);
            check("t1_done",  32'(bus.done),  32'd0);
            tick();
        end
        check("t1_done5",    32'(bus.done),    32'd1);
        check("t1_product",  32'(bus.product), 32'h0F);
        tick();
        check("t1_done6",    32'(bus.done),    32'd0);
        check("t1_ready6",   32'(bus.ready),   32'd1);
        check("t1_hold6",    32'(bus.product), 32'h0F);

        // 2. Corner operands
        for (int i = 0; i < 4; i++) begin
            tick();
            start_op(c_md[i], c_mr[i]);
            wait_done(10);
            check("t2_corner", 32'(bus.product), 32'(c_p[i]));
        end

        // 3. Exhaustive sweep, each start issued in the previous done cycle
        prev_acc = 0;
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            start_op(v[7:4], v[3:0]);
            if (i > 0) check("t3_interval", 32'(last_accept - prev_acc), 32'd5);
            prev_acc = last_accept;
            wait_done(10);
        end

        // 4. start held high with changing operands
        tick();
        tick();
        base_cyc  = cyc;
        base_acc  = accepts;
        base_done = dones;
        bus.start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.md = W'($urandom_range(0, 15));
            bus.mr = W'($urandom_range(0, 15));
            n_acc  = accepts;
            tick();
            if (accepts != n_acc) check("t4_phase", 32'((last_accept - base_cyc) % 5), 32'd0);
        end
        bus.start = 1'b0;
        check("t4_accepts", 32'(accepts - base_acc), 32'd4);
        wait_done(10);
        check("t4_dones",   32'(dones - base_done), 32'd4);
        check("t4_drained", 32'(exp_q.size()),      32'd0);

        // 5a. Operands changed mid-run do not disturb the result
        tick();
        start_op(4'd3, 4'd5);
        tick();
        bus.md = 4'h9;
        bus.mr = 4'h6;
        wait_done(10);
        check("t5_stable", 32'(bus.product), 32'h0F);

        // 5b. Reset in cycle 3 aborts the operation
        tick();
        start_op(4'd3, 4'd5);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy",    32'(bus.busy),    32'd0);
        check("t5_rst_ready",   32'(bus.ready),   32'd1);
        check("t5_rst_product", 32'(bus.product), 32'd0);
        check("t5_rst_done",    32'(bus.done),    32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base_done = dones;
        repeat (8) tick();
        check("t5_no_done", 32'(dones - base_done), 32'd0);
        start_op(4'd2, 4'hE);
        wait_done(10);
        check("t5_fresh", 32'(bus.product), 32'hFC);

        // 6. Back-to-back issue from the done cycle
        tick();
        start_op(4'd1, 4'd1);
        wait_done(10);
        check("t6_first", 32'(bus.product), 32'h01);
        c5 = cyc;
        start_op(4'd7, 4'd7);
        for (int c = 6; c <= 9; c++) begin
            check("t6_hold", 32'(bus.product), 32'h01);
            check("t6_busy", 32'(bus.busy),    32'd1);
            tick();
        end
        check("t6_done",    32'(bus.done),    32'd1);
        check("t6_second",  32'(bus.product), 32'h31);
        check("t6_spacing", 32'(cyc - c5),    32'd5);

        tick();
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
